sg_read_sequencer: RTL
======================

# sg_read_sequencer

Scatter-gather request sequencer directly upstream of the AXI-to-FIFO reader. Accepts a stream of (address, length, last) segment descriptors, buffers them, splits each segment into memory-read requests of at most MAX_REQ_LEN bytes, and issues them one at a time on the memory-read request port (start/addr/len/cont, busy/done/error). Sets `cont` so the downstream stuffer emits exactly one SOF/EOF per frame. Reports per-frame completion, byte count and sticky error.

## Interface
- ADDR_WIDTH, 32: segment/request address width.
- LEN_WIDTH, 16: segment/request length width, bytes.
- MAX_REQ_LEN, 2048: largest single request; ≤ downstream FIFO_SIZE in bytes, > 0.
- DESC_DEPTH, 4: descriptor FIFO depth; power of two, ≥ 2.

- clock  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- seg_valid  in  1  descriptor offered.
- seg_ready  out  1  descriptor FIFO not full.
- seg_addr  in  ADDR_WIDTH  segment start byte address (any alignment).
- seg_len  in  LEN_WIDTH  segment length, bytes.
- seg_last  in  1  final segment of frame.
- mr_start  out  1  one-cycle request pulse.
- mr_addr  out  ADDR_WIDTH  request address, valid with mr_start.
- mr_len  out  LEN_WIDTH  request length, valid with mr_start.
- mr_cont  out  1  1 = frame continues after this request.
- mr_busy  in  1  reader busy.
- mr_done  in  1  reader completion pulse.
- mr_error  in  1  reader error, valid with mr_done.
- frame_done  out  1  one-cycle pulse, frame finished.
- frame_error  out  1  valid with frame_done; any request/segment error in frame.
- frame_bytes  out  32  valid with frame_done; sum of segment lengths issued, mod 2^32.
- idle  out  1  FIFO empty and FSM in IDLE.

## Operation
- Descriptor FIFO: write on seg_valid & seg_ready; seg_ready = !full (registered count, no same-cycle push-through when full even if popping).
- Working regs: cur_addr, remaining, cur_last, chunk_len, err_sticky, byte_acc.
- FSM states IDLE, ISSUE, WAIT.
- IDLE: FIFO non-empty -> pop into cur_addr/remaining/cur_last, go ISSUE. Popped seg_len == 0: no request issued, err_sticky <= 1; if seg_last, pulse frame_done (frame_error=1), clear accumulators; stay IDLE.
- ISSUE: wait for mr_busy == 0; then pulse mr_start with mr_addr = cur_addr, mr_len = chunk_len = min(remaining, MAX_REQ_LEN), mr_cont = !(cur_last && remaining == chunk_len); go WAIT.
- WAIT: on mr_done: err_sticky |= mr_error; cur_addr += chunk_len (wraps mod 2^ADDR_WIDTH); remaining -= chunk_len; byte_acc += chunk_len. remaining now > 0 -> ISSUE. Else if cur_last -> frame_done pulse with frame_error = err_sticky, frame_bytes = byte_acc; clear err_sticky/byte_acc; -> IDLE. Else -> IDLE.
- Errors never abort: remaining chunks/segments still issued so downstream sees EOF.
- mr_done outside WAIT ignored.

## Timing
- Reset: seg_ready=0 during reset, 1 the cycle after; mr_start=0, mr_addr=0, mr_len=0, mr_cont=0, frame_done=0, frame_error=0, frame_bytes=0, idle=1; FIFO emptied, FSM IDLE, accumulators 0.
- Reset mid-request: request abandoned; a later mr_done for it is ignored (FSM in IDLE).
- Latency: descriptor accepted at edge N into empty FIFO, FSM IDLE, mr_busy=0 -> popped at N+1, mr_start high in cycle after edge N+2.
- mr_done at edge M with remaining > 0 and mr_busy=0 -> next mr_start high after edge M+1 (one ISSUE cycle).
- frame_done high exactly one cycle, registered, cycle after the final mr_done edge.
- At most one request outstanding; mr_start never asserted while mr_busy=1 or in WAIT.
- Simultaneous FIFO push and pop: count unchanged; push/pop on full/empty gated by ready/non-empty.
- chunk_len compare in LEN_WIDTH+1 bits; MAX_REQ_LEN ≥ 2^LEN_WIDTH means no splitting.

## Test plan
- Single segment addr 0x1000 len 100 last=1 -> one mr_start addr 0x1000 len 100 cont 0; after mr_done, frame_done with frame_bytes 100, frame_error 0.
- Split: addr 0x1000 len 5000 last=1 -> starts (0x1000,2048,cont1), (0x1800,2048,cont1), (0x2000,904,cont0); frame_bytes 5000.
- Multi-segment frame: (0x100,64,last0),(0x8003,37,last1) -> cont 1 then 0; single frame_done, frame_bytes 101.
- Backpressure: hold mr_done low, offer 6 descriptors -> 1 popped, seg_ready low after 4 queued; all 6 issued in order once done pulses resume.
- Errors: mr_error on 2nd of 3 chunks -> third chunk still issued, frame_error=1; next frame frame_error=0. Zero-length last segment -> no mr_start, frame_done with frame_error 1.
- Reset asserted in WAIT, then stray mr_done -> no mr_start, idle=1, frame_done stays 0.

Source files
------------

// File: rtl/sg_read_sequencer.sv
// Scatter-gather read sequencer: buffers segment descriptors, splits each segment into
// bounded memory-read requests and reports per-frame byte count and sticky error.
module sg_read_sequencer #(
    parameter int ADDR_WIDTH  = 32,
    parameter int LEN_WIDTH   = 16,
    parameter int MAX_REQ_LEN = 2048,
    parameter int DESC_DEPTH  = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  seg_valid,
    output logic                  seg_ready,
    input  logic [ADDR_WIDTH-1:0] seg_addr,
    input  logic [LEN_WIDTH-1:0]  seg_len,
    input  logic                  seg_last,
    output logic                  mr_start,
    output logic [ADDR_WIDTH-1:0] mr_addr,
    output logic [LEN_WIDTH-1:0]  mr_len,
    output logic                  mr_cont,
    input  logic                  mr_busy,
    input  logic                  mr_done,
    input  logic                  mr_error,
    output logic                  frame_done,
    output logic                  frame_error,
    output logic [31:0]           frame_bytes,
    output logic                  idle
);

    localparam int PTR_W = $clog2(DESC_DEPTH);

    // A request limit at or beyond the length range means segments are never split.
    localparam logic [LEN_WIDTH:0] LEN_SPAN = {1'b1, {LEN_WIDTH{1'b0}}};
    localparam logic [LEN_WIDTH:0] MAX_CMP  =
        (64'(MAX_REQ_LEN) >= (64'd1 << LEN_WIDTH)) ? LEN_SPAN : (LEN_WIDTH+1)'(MAX_REQ_LEN);

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [LEN_WIDTH-1:0]  len;
        logic                  last;
    } seg_desc_t;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    seg_desc_t             fifo_mem [DESC_DEPTH];
    seg_desc_t             desc_in;
    seg_desc_t             head;
    logic [PTR_W-1:0]      wr_ptr, rd_ptr;
    logic [PTR_W:0]        count;
    logic                  full, empty, push, pop;

    state_t                state, state_d;
    logic                  issue, chunk_done, last_chunk, frame_end;
    logic [ADDR_WIDTH-1:0] cur_addr;
    logic [LEN_WIDTH-1:0]  remaining, chunk_len, chunk_c;
    logic                  cur_last, err_sticky, err_n;
    logic [31:0]           byte_acc, acc_n;

    assign desc_in   = '{addr: seg_addr, len: seg_len, last: seg_last};
    assign head      = fifo_mem[rd_ptr];
    assign full      = (count == (PTR_W+1)'(DESC_DEPTH));
    assign empty     = (count == '0);
    assign seg_ready = !full && !reset;
    assign push      = seg_valid && seg_ready;
    assign idle      = empty && (state == IDLE);

    always_ff @(posedge clock) begin
        if (push) fifo_mem[wr_ptr] <= desc_in;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + (PTR_W+1)'(1);
                2'b01:   count <= count - (PTR_W+1)'(1);
                default: count <= count;
            endcase
        end
    end

    assign chunk_c    = ({1'b0, remaining} > MAX_CMP) ? MAX_CMP[LEN_WIDTH-1:0] : remaining;
    assign last_chunk = (remaining == chunk_len);
    assign frame_end  = chunk_done && last_chunk && cur_last;
    assign err_n      = err_sticky | mr_error;
    assign acc_n      = byte_acc + 32'(chunk_len);

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_d;
    end

    always_comb begin
        state_d    = state;
        pop        = 1'b0;
        issue      = 1'b0;
        chunk_done = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    pop = 1'b1;
                    // Zero-length segments are consumed in place without a request.
                    if (head.len != '0) state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (!mr_busy) begin
                    issue   = 1'b1;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (mr_done) begin
                    chunk_done = 1'b1;
                    state_d    = last_chunk ? IDLE : ISSUE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cur_addr    <= '0;
            remaining   <= '0;
            cur_last    <= 1'b0;
            chunk_len   <= '0;
            err_sticky  <= 1'b0;
            byte_acc    <= '0;
            mr_start    <= 1'b0;
            mr_addr     <= '0;
            mr_len      <= '0;
            mr_cont     <= 1'b0;
            frame_done  <= 1'b0;
            frame_error <= 1'b0;
            frame_bytes <= '0;
        end else begin
            mr_start   <= issue;
            frame_done <= 1'b0;
            if (pop) begin
                cur_addr  <= head.addr;
                remaining <= head.len;
                cur_last  <= head.last;
                if (head.len == '0) begin
                    if (head.last) begin
                        frame_done  <= 1'b1;
                        frame_error <= 1'b1;
                        frame_bytes <= byte_acc;
                        err_sticky  <= 1'b0;
                        byte_acc    <= '0;
                    end else begin
                        err_sticky  <= 1'b1;
                    end
                end
            end
            if (issue) begin
                chunk_len <= chunk_c;
                mr_addr   <= cur_addr;
                mr_len    <= chunk_c;
                mr_cont   <= !(cur_last && (remaining == chunk_c));
            end
            if (chunk_done) begin
                cur_addr  <= cur_addr + ADDR_WIDTH'(chunk_len);
                remaining <= remaining - chunk_len;
                if (frame_end) begin
                    frame_done  <= 1'b1;
                    frame_error <= err_n;
                    frame_bytes <= acc_n;
                    err_sticky  <= 1'b0;
                    byte_acc    <= '0;
                end else begin
                    err_sticky  <= err_n;
                    byte_acc    <= acc_n;
                end
            end
        end
    end

endmodule
